reg_dump: RTL and testbench
===========================

# reg_dump

Read-side sequencer for the 8x8 register file. On a START pulse it walks every register through the two asynchronous read ports (OUT1ADDRESS/OUT2ADDRESS, two registers per step) and streams each value, tagged with its index, out on a VALID/READY interface. It sits beside the register file as a debug/scan port. The writer side and the data path keep ownership of IN/INADDRESS/WRITE.

## Interface

Parameters:
- NREGS, 8, registers dumped; must equal 2**ADDR_W and be even
- ADDR_W, 3, register address width
- DATA_W, 8, register data width
- SETTLE, 1, extra cycles the read addresses are held before capture; covers the register file's read delay; range 0..7

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-low reset; sampled only at a CLK rising edge
- START  in  1  begin-dump request; sampled only in IDLE
- OUT1ADDRESS  out  ADDR_W  register file read port 1 address
- OUT2ADDRESS  out  ADDR_W  register file read port 2 address
- OUT1  in  DATA_W  register file read port 1 data
- OUT2  in  DATA_W  register file read port 2 data
- DATA  out  DATA_W  streamed register value
- INDEX  out  ADDR_W  register number of DATA
- VALID  out  1  DATA/INDEX valid
- READY  in  1  consumer accepts; a beat transfers on an edge where VALID&&READY
- BUSY  out  1  dump in progress
- DONE  out  1  one-cycle pulse after the last beat transfers

## Operation

- FSM states: IDLE, WAIT, SEND0, SEND1. The pair counter p runs 0..NREGS/2-1. The wait counter cnt is 3 bits.
- IDLE: VALID=0, BUSY=0, addresses=0.
  - START=1 at an edge: p<=0, OUT1ADDRESS<=0, OUT2ADDRESS<=1, cnt<=SETTLE, BUSY<=1, go to WAIT.
- WAIT: addresses held at 2p and 2p+1.
  - Edge with cnt!=0: decrement cnt.
  - Edge with cnt==0: capture OUT1 into buf0 and OUT2 into buf1, then go to SEND0.
- SEND0: VALID=1, DATA=buf0, INDEX=2p. On transfer, go to SEND1.
- SEND1: VALID=1, DATA=buf1, INDEX=2p+1. On transfer:
  - If p==NREGS/2-1: go to IDLE, VALID<=0, BUSY<=0, DONE<=1.
  - Otherwise: p<=p+1, addresses<=2p+2 and 2p+3, cnt<=SETTLE, go to WAIT.
- DONE is high for exactly one cycle and self-clears on the next edge.
- While VALID=1 and READY=0, DATA, INDEX and VALID hold stable. VALID never drops before its transfer.
- START outside IDLE is ignored. It is not queued.
- The dump is not atomic. A register write that lands before that register's capture edge is reflected in the dump; a later write is not.
- Reset (RESET=0 at an edge) overrides everything and aborts any dump in progress with no DONE. Reset values: OUT1ADDRESS=0, OUT2ADDRESS=0, DATA=0, INDEX=0, VALID=0, BUSY=0, DONE=0, state IDLE, p=0, cnt=0.

## Timing

- Edge numbering: E0 is the edge that samples START in IDLE.
- Addresses are valid from E0. The capture edge for pair p is E0 + p*(SETTLE+3) + SETTLE+1, so addresses are stable for SETTLE+1 full cycles before capture.
- With READY held at 1:
  - Index 2p transfers at capture+1 and index 2p+1 at capture+2.
  - The last beat transfers at E0 + (NREGS/2)*(SETTLE+3). With defaults this is E16.
  - DONE is high from E16 to E17, and BUSY falls at E16.
  - The earliest next START is accepted at E17.
- Each READY-low cycle during SEND0/SEND1 delays all later events by one cycle.
- RESET going low between edges has no effect until the next edge.

## Test plan

- Preload via writes: reg1=AA, reg3=55, reg5=FF, all others reset to 00. START pulse with READY=1 -> beats (INDEX,DATA) = (0,00)(1,AA)(2,00)(3,55)(4,00)(5,FF)(6,00)(7,00). The last beat transfers at E16, DONE is high E16-E17, BUSY falls at E16.
- Same preload with READY high only one cycle in three -> same 8 beats in order. DATA/INDEX do not change while VALID=1 and READY=0. DONE asserts only after beat 7.
- START held high for 40 cycles -> exactly one dump per IDLE visit. The second START is accepted at E17 and again yields 8 beats starting at INDEX 0.
- RESET=0 at the edge after beat 2 transfers -> next cycle all outputs are 0 and there is no DONE. A following START produces a full 8-beat dump from INDEX 0.
- RESET pulsed low between edges only (not at any rising edge) -> dump unaffected, all 8 beats delivered.
- SETTLE=3 with READY=1 -> first capture at E4, last beat at E24, DONE high E24-E25. Data matches the preload.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: read-side sequencer for the register file debug/scan port.
// On START it walks every register pair through the two asynchronous read
// ports and streams each value, tagged with its index, on a VALID/READY port.
//
// Ports:
//   CLK          rising-edge clock
//   RESET        synchronous active-low reset
//   START        begin-dump request, honoured only when idle
//   OUT1ADDRESS  read port 1 address (even register of the pair)
//   OUT2ADDRESS  read port 2 address (odd register of the pair)
//   OUT1/OUT2    read port data
//   DATA/INDEX   streamed value and its register number
//   VALID/READY  stream handshake; a beat moves on an edge with both high
//   BUSY         dump in progress
//   DONE         one-cycle pulse after the last beat transfers
module reg_dump #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic [ADDR_W-1:0] OUT1ADDRESS,
  output logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic [DATA_W-1:0] OUT1,
  input  logic [DATA_W-1:0] OUT2,
  output logic [DATA_W-1:0] DATA,
  output logic [ADDR_W-1:0] INDEX,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned P_W    = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [P_W-1:0] P_LAST = P_W'(NREGS / 2 - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND0, SEND1} state_t;

  state_t              r_state, w_state;
  logic [P_W-1:0]      r_p, w_p;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [DATA_W-1:0]   r_buf1, w_buf1;
  logic [ADDR_W-1:0]   r_addr1, w_addr1;
  logic [ADDR_W-1:0]   r_addr2, w_addr2;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [ADDR_W-1:0]   r_index, w_index;
  logic                r_valid, w_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_cnt   <= '0;
      r_buf1  <= '0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_data  <= '0;
      r_index <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_p     <= w_p;
      r_cnt   <= w_cnt;
      r_buf1  <= w_buf1;
      r_addr1 <= w_addr1;
      r_addr2 <= w_addr2;
      r_data  <= w_data;
      r_index <= w_index;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state = r_state;
    w_p     = r_p;
    w_cnt   = r_cnt;
    w_buf1  = r_buf1;
    w_addr1 = r_addr1;
    w_addr2 = r_addr2;
    w_data  = r_data;
    w_index = r_index;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_state = WAIT;
          w_p     = '0;
          w_addr1 = '0;
          w_addr2 = ADDR_W'(1);
          w_cnt   = CNT_W'(SETTLE);
          w_busy  = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else begin
          // Even register goes straight to DATA; odd one is parked for SEND1
          w_data  = OUT1;
          w_buf1  = OUT2;
          w_index = r_addr1;
          w_valid = 1'b1;
          w_state = SEND0;
        end
      end
      SEND0: begin
        if (READY) begin
          w_data  = r_buf1;
          w_index = r_addr2;
          w_state = SEND1;
        end
      end
      SEND1: begin
        if (READY) begin
          w_valid = 1'b0;
          if (r_p == P_LAST) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_p     = '0;
            w_addr1 = '0;
            w_addr2 = '0;
          end else begin
            w_state = WAIT;
            w_p     = r_p + P_W'(1);
            w_addr1 = r_addr1 + ADDR_W'(2);
            w_addr2 = r_addr2 + ADDR_W'(2);
            w_cnt   = CNT_W'(SETTLE);
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign OUT1ADDRESS = r_addr1;
  assign OUT2ADDRESS = r_addr2;
  assign DATA        = r_data;
  assign INDEX       = r_index;
  assign VALID       = r_valid;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: a behavioural 8x8 register file feeds two
// instances (SETTLE=1 and SETTLE=3); beats, timing and DONE/BUSY are checked
// against hand-derived edge numbers.
module tb_reg_dump;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       start3;
  logic       READY;
  logic [7:0] regs [8];

  logic [2:0] a1, a2, a1_3, a2_3;
  logic [7:0] o1, o2, o1_3, o2_3;
  logic [7:0] data1, data3;
  logic [2:0] idx1, idx3;
  logic       v1, v3, busy1, busy3, done1, done3;

  logic       sel3;
  logic [7:0] s_data;
  logic [2:0] s_index;
  logic       s_valid, s_busy, s_done;

  int n_checks;
  int n_errors;

  assign o1   = regs[a1];
  assign o2   = regs[a2];
  assign o1_3 = regs[a1_3];
  assign o2_3 = regs[a2_3];

  always_comb begin
    s_data  = sel3 ? data3 : data1;
    s_index = sel3 ? idx3  : idx1;
    s_valid = sel3 ? v3    : v1;
    s_busy  = sel3 ? busy3 : busy1;
    s_done  = sel3 ? done3 : done1;
  end

  reg_dump #(.NREGS(8), .ADDR_W(3), .DATA_W(8), .SETTLE(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .OUT1ADDRESS(a1), .OUT2ADDRESS(a2), .OUT1(o1), .OUT2(o2),
    .DATA(data1), .INDEX(idx1), .VALID(v1), .READY(READY),
    .BUSY(busy1), .DONE(done1)
  );

  reg_dump #(.NREGS(8), .ADDR_W(3), .DATA_W(8), .SETTLE(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(start3),
    .OUT1ADDRESS(a1_3), .OUT2ADDRESS(a2_3), .OUT1(o1_3), .OUT2(o2_3),
    .DATA(data3), .INDEX(idx3), .VALID(v3), .READY(READY),
    .BUSY(busy3), .DONE(done3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  // One full dump. mode 0: READY always high; mode 1: READY one cycle in three.
  // first_e/last_e: expected edge (relative to E0) of the first/last transfer, 0 = skip.
  task automatic do_dump(input int mode, input int first_e, input int last_e,
                         input bit glitch);
    int         k;
    int         nb;
    bit         pv;
    logic [7:0] pd;
    logic [2:0] pi;
    logic       prdy;
    @(negedge CLK);
    if (sel3) start3 = 1'b1; else START = 1'b1;
    READY = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    START  = 1'b0;
    start3 = 1'b0;
    k = 0; nb = 0; pv = 0; prdy = 1'b0; pd = '0; pi = '0;
    while (nb < 8 && k < 300) begin
      if (pv && !prdy) begin
        check("hold_data",  s_data,  pd);
        check("hold_index", s_index, pi);
        check("hold_valid", s_valid, 1);
      end
      check("busy_high",  s_busy, 1);
      check("done_early", s_done, 0);
      READY = (mode == 0) ? 1'b1 : ((k % 3) == 2);
      if (s_valid && READY) begin
        check("beat_index", s_index, nb);
        check("beat_data",  s_data,  regs[nb]);
        if (nb == 0 && first_e > 0) check("first_edge", k + 1, first_e);
        if (nb == 7 && last_e > 0)  check("last_edge",  k + 1, last_e);
        nb++;
      end
      pv = s_valid; pd = s_data; pi = s_index; prdy = READY;
      if (glitch && k == 5) begin
        #1 RESET = 1'b0;
        #2 RESET = 1'b1;
      end
      @(posedge CLK);
      k++;
      @(negedge CLK);
    end
    if (nb < 8) check("dump_timeout", nb, 8);
    check("done_pulse", s_done,  1);
    check("busy_fall",  s_busy,  0);
    check("valid_fall", s_valid, 0);
    READY = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("done_clear", s_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nb;
    int ndone;
    int dseen;
    n_checks = 0;
    n_errors = 0;
    sel3   = 1'b0;
    RESET  = 1'b0;
    START  = 1'b0;
    start3 = 1'b0;
    READY  = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    regs[1] = 8'hAA;
    regs[3] = 8'h55;
    regs[5] = 8'hFF;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_addr1", a1, 0);
    check("rst_addr2", a2, 0);
    check("rst_data",  data1, 0);
    check("rst_index", idx1, 0);
    check("rst_valid", v1, 0);
    check("rst_busy",  busy1, 0);
    check("rst_done",  done1, 0);
    check("rst_busy3", busy3, 0);
    RESET = 1'b1;

    // Full-rate dump: first beat E3, last beat E16
    do_dump(0, 3, 16, 1'b0);

    // Throttled READY: same beats, stable while stalled
    do_dump(1, 0, 0, 1'b0);

    // START held for 40 cycles: one dump per IDLE visit, restarts at E17 and E34
    @(negedge CLK);
    START = 1'b1;
    READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    k = 0; nb = 0; ndone = 0;
    while (k < 200 && ndone < 3) begin
      if (k == 39) START = 1'b0;
      if (k == 16) check("held_busy_e16", s_busy, 0);
      if (k == 17) check("held_busy_e17", s_busy, 1);
      if (s_done) ndone++;
      if (s_valid) begin
        check("held_index", s_index, nb % 8);
        check("held_data",  s_data,  regs[nb % 8]);
        nb++;
      end
      @(posedge CLK);
      k++;
      @(negedge CLK);
    end
    START = 1'b0;
    check("held_dumps", ndone, 3);
    check("held_beats", nb, 24);
    repeat (3) @(negedge CLK);
    check("held_no_queue", s_busy, 0);

    // Reset at E8, the edge after beat 2 transfers at E7
    @(negedge CLK);
    START = 1'b1;
    READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    check("pre_rst_index", s_index, 3);
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    check("abort_addr1", a1, 0);
    check("abort_addr2", a2, 0);
    check("abort_data",  data1, 0);
    check("abort_index", idx1, 0);
    check("abort_valid", v1, 0);
    check("abort_busy",  busy1, 0);
    check("abort_done",  done1, 0);
    dseen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done1) dseen++;
    end
    check("abort_no_done", dseen, 0);
    do_dump(0, 3, 16, 1'b0);

    // RESET pulsed low between edges only
    do_dump(0, 3, 16, 1'b1);

    // SETTLE=3: capture E4, first beat E5, last beat E24
    sel3 = 1'b1;
    do_dump(0, 5, 24, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
